// File: rtl/icache_dm_refill_pkg.sv
// Shared types and width helpers for the direct-mapped refill icache.
// Optional perf counters are enabled with ICACHE_PERF_CNT_EN.
package icache_dm_refill_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REQ,
    FILL,
    DONE
  } state_e;

  function automatic int off_bits(input int w_line);
    return $clog2(w_line / 8);
  endfunction

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_dm_refill_if.sv
// Fetch-queue and memory-port bundle of the refill icache.
// Cache side uses the slave modport.
interface icache_dm_refill_if #(
  parameter int W_IDATA = 32,
  parameter int W_ODATA = 128,
  parameter int W_MEM   = 32
);
  logic [W_IDATA-1:0] ifq_pcin;
  logic               ifq_ren;
  logic               ifq_abort;
  logic               ifq_ready;
  logic [W_ODATA-1:0] ifq_dout;
  logic               ifq_dout_valid;
  logic               ic_flush;
  logic               mem_req;
  logic [W_IDATA-1:0] mem_addr;
  logic               mem_gnt;
  logic [W_MEM-1:0]   mem_rdata;
  logic               mem_rvalid;

  modport slave (
    input  ifq_pcin, ifq_ren, ifq_abort, ic_flush,
    input  mem_gnt, mem_rdata, mem_rvalid,
    output ifq_ready, ifq_dout, ifq_dout_valid,
    output mem_req, mem_addr
  );

  modport master (
    output ifq_pcin, ifq_ren, ifq_abort, ic_flush,
    output mem_gnt, mem_rdata, mem_rvalid,
    input  ifq_ready, ifq_dout, ifq_dout_valid,
    input  mem_req, mem_addr
  );
endinterface

// File: rtl/icache_tag_array.sv
// Valid+tag storage: combinational lookup, synchronous write,
// single-cycle flush of all valid bits.
module icache_tag_array #(
  parameter int W_INDEX = 6,
  parameter int W_TAG   = 22
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               we_i,
  input  logic               wvalid_i,
  input  logic [W_INDEX-1:0] idx_i,
  input  logic [W_TAG-1:0]   tag_i,
  output logic               hit_o
);
  localparam int N_LINE = 1 << W_INDEX;

  logic [N_LINE-1:0] valid_q;
  logic [W_TAG-1:0]  tag_q [N_LINE];

  // flush beats a same-cycle install
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        valid_q <= '0;
    else if (flush_i) valid_q <= '0;
    else if (we_i)    valid_q[idx_i] <= wvalid_i;
  end

  always_ff @(posedge clk) begin
    if (we_i) tag_q[idx_i] <= tag_i;
  end

  assign hit_o = valid_q[idx_i] & (tag_q[idx_i] == tag_i);

endmodule

// File: rtl/icache_dm_refill.sv
// Direct-mapped icache with burst refill, abort and flush.
// ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
module icache_dm_refill
  import icache_dm_refill_pkg::*;
#(
  parameter int W_IDATA = 32,
  parameter int W_ODATA = 128,
  parameter int W_INDEX = 6,
  parameter int W_MEM   = 32
)(
  input  logic clk,
  input  logic reset,
  icache_dm_refill_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);
  localparam int W_OFF  = off_bits(W_ODATA);
  localparam int W_TAG  = W_IDATA - W_INDEX - W_OFF;
  localparam int N_BEAT = W_ODATA / W_MEM;
  localparam int W_BEAT = cnt_bits(N_BEAT);
  localparam int N_LINE = 1 << W_INDEX;
  localparam logic [W_IDATA-1:0] OFF_MASK =
    W_IDATA'((64'd1 << W_OFF) - 64'd1);

  state_e             state_q, state_d;
  logic [W_IDATA-1:0] pc_q, pc_d;
  logic [W_BEAT-1:0]  beat_q, beat_d;
  logic [W_ODATA-1:0] buf_q, buf_d;
  logic               abort_q, abort_d;
  logic               flush_q, flush_d;

  logic               hit, we, wvalid;
  logic               lk_hit, lk_miss;
  logic               ready, dvalid, mreq;
  logic [W_ODATA-1:0] dout;
  logic [W_INDEX-1:0] idx;
  logic [W_TAG-1:0]   tag;
  logic               accept;
  logic [W_ODATA-1:0] data_q [N_LINE];

  assign idx    = pc_q[W_OFF +: W_INDEX];
  assign tag    = pc_q[W_IDATA-1 -: W_TAG];
  assign accept = bus.ifq_ren & ready & ~bus.ifq_abort;

  icache_tag_array #(
    .W_INDEX (W_INDEX),
    .W_TAG   (W_TAG)
  ) u_tags (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (bus.ic_flush),
    .we_i     (we),
    .wvalid_i (wvalid),
    .idx_i    (idx),
    .tag_i    (tag),
    .hit_o    (hit)
  );

  always_ff @(posedge clk) begin
    if (we) data_q[idx] <= buf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      beat_q  <= '0;
      buf_q   <= '0;
      abort_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
      abort_q <= abort_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    beat_d  = beat_q;
    buf_d   = buf_q;
    abort_d = abort_q;
    flush_d = flush_q;
    ready   = 1'b0;
    dvalid  = 1'b0;
    dout    = '0;
    mreq    = 1'b0;
    we      = 1'b0;
    wvalid  = 1'b0;
    lk_hit  = 1'b0;
    lk_miss = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (accept) begin
          pc_d    = bus.ifq_pcin & ~OFF_MASK;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        ready = hit;
        if (bus.ifq_abort) begin
          state_d = IDLE;
        end else if (hit) begin
          lk_hit = 1'b1;
          dvalid = 1'b1;
          dout   = data_q[idx];
          if (accept) pc_d = bus.ifq_pcin & ~OFF_MASK;
          else        state_d = IDLE;
        end else begin
          lk_miss = 1'b1;
          beat_d  = '0;
          abort_d = 1'b0;
          flush_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        mreq    = 1'b1;
        abort_d = abort_q | bus.ifq_abort;
        flush_d = flush_q | bus.ic_flush;
        if (bus.mem_gnt) state_d = FILL;
      end
      FILL: begin
        abort_d = abort_q | bus.ifq_abort;
        flush_d = flush_q | bus.ic_flush;
        if (bus.mem_rvalid) begin
          buf_d[beat_q*W_MEM +: W_MEM] = bus.mem_rdata;
          beat_d = beat_q + 1'b1;
          if (beat_q == W_BEAT'(N_BEAT - 1)) state_d = DONE;
        end
      end
      DONE: begin
        // a flush seen during the burst installs the line invalid
        we      = 1'b1;
        wvalid  = ~flush_q;
        dvalid  = ~abort_q;
        dout    = buf_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ifq_ready      = ready;
  assign bus.ifq_dout       = dout;
  assign bus.ifq_dout_valid = dvalid;
  assign bus.mem_req        = mreq;
  assign bus.mem_addr       = mreq ? pc_q : '0;

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (bus.ic_flush) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else begin
      if (lk_hit && perf_hit_cnt != '1)
        perf_hit_cnt <= perf_hit_cnt + 32'd1;
      if (lk_miss && perf_miss_cnt != '1)
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm_refill.sv
// Scoreboard bench for icache_dm_refill with a burst memory model.
// Perf counter checks are built when ICACHE_PERF_CNT_EN is defined.
module tb_icache_dm_refill;
  localparam int W_IDATA = 32;
  localparam int W_ODATA = 128;
  localparam int W_MEM   = 32;
  localparam int N_BEAT  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  icache_dm_refill_if #(
    .W_IDATA (W_IDATA),
    .W_ODATA (W_ODATA),
    .W_MEM   (W_MEM)
  ) bus ();

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

  icache_dm_refill #(
    .W_IDATA (W_IDATA),
    .W_ODATA (W_ODATA),
    .W_INDEX (6),
    .W_MEM   (W_MEM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .perf_hit_cnt  (perf_hit_cnt),
    .perf_miss_cnt (perf_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rcv = 0;
  int bursts = 0;
  int cur_beat = -1;
  int gnt_wait = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [W_ODATA-1:0] exp_q [$];
  logic [W_ODATA-1:0] last_dout = '0;
  logic [31:0] last_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input int k);
    if (a == 32'h40) return 32'(k + 1) * 32'h11;
    return {8'(k), a[23:0]} ^ 32'hA500_0000;
  endfunction

  function automatic logic [W_ODATA-1:0] line_of(input logic [31:0] a);
    logic [W_ODATA-1:0] l;
    logic [31:0] b;
    b = a & ~32'hF;
    l = '0;
    for (int k = 0; k < N_BEAT; k++) l[k*W_MEM +: W_MEM] = mem_word(b, k);
    return l;
  endfunction

  // scoreboard monitor
  initial begin
    logic [W_ODATA-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.ifq_dout_valid === 1'b1) begin
        rcv++;
        last_dout = bus.ifq_dout;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dout got=%h expected=no response", bus.ifq_dout);
        end else begin
          e = exp_q.pop_front();
          if (bus.ifq_dout !== e) begin
            errors++;
            $display("FAIL dout got=%h expected=%h", bus.ifq_dout, e);
          end
        end
      end
    end
  end

  // memory burst responder
  initial begin
    int ph, wcnt;
    logic [31:0] baddr;
    ph = 0; wcnt = 0; baddr = '0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        ph = 0; wcnt = 0; cur_beat = -1;
      end else begin
        case (ph)
          0: if (bus.mem_req === 1'b1) begin
            if (wcnt < gnt_wait) wcnt++;
            else begin
              bus.mem_gnt = 1'b1;
              baddr = bus.mem_addr;
              last_addr = baddr;
              bursts++;
              wcnt = 0;
              ph = 1;
            end
          end
          1: begin
            bus.mem_gnt = 1'b0;
            cur_beat = 0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = mem_word(baddr, 0);
            ph = 2;
          end
          default: begin
            cur_beat++;
            if (cur_beat == N_BEAT) begin
              bus.mem_rvalid = 1'b0;
              cur_beat = -1;
              ph = 0;
            end else begin
              bus.mem_rdata = mem_word(baddr, cur_beat);
            end
          end
        endcase
      end
    end
  end

  task automatic do_fetch(input logic [31:0] addr, input bit miss,
                          input int abort_beat, input int flush_beat,
                          input int lat_exp);
    int r0, b0, n, lat;
    r0 = rcv; b0 = bursts; n = 0; lat = 0;
    if (abort_beat < 0) exp_q.push_back(line_of(addr));
    @(negedge clk);
    bus.ifq_pcin = addr;
    bus.ifq_ren = 1'b1;
    #1;
    while (bus.ifq_ready !== 1'b1 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      bus.ifq_ren = 1'b0;
      $display("FAIL accept_%h got=ready low expected=accept", addr);
      return;
    end
    @(negedge clk);
    bus.ifq_ren = 1'b0;
    #1;
    while (rcv == r0 && lat < 40) begin
      @(negedge clk); #1; lat++;
      bus.ic_flush = 1'b0;
      bus.ifq_abort = 1'b0;
      if (flush_beat >= 0 && cur_beat == flush_beat) bus.ic_flush = 1'b1;
      if (abort_beat >= 0 && cur_beat == abort_beat) bus.ifq_abort = 1'b1;
    end
    bus.ic_flush = 1'b0;
    bus.ifq_abort = 1'b0;
    if (miss) exp_misses++; else exp_hits++;
    checks++;
    if (abort_beat >= 0) begin
      if (rcv != r0) begin
        errors++;
        $display("FAIL abort_%h got=%0d responses expected=0", addr, rcv - r0);
      end
    end else if (rcv != r0 + 1) begin
      errors++;
      $display("FAIL resp_%h got=%0d responses expected=1", addr, rcv - r0);
    end else begin
      checks++;
      if (lat != lat_exp) begin
        errors++;
        $display("FAIL latency_%h got=%0d expected=%0d", addr, lat, lat_exp);
      end
    end
    checks++;
    if (bursts - b0 != int'(miss)) begin
      errors++;
      $display("FAIL bursts_%h got=%0d expected=%0d", addr, bursts - b0, miss);
    end
    if (miss) begin
      checks++;
      if (last_addr !== (addr & ~32'hF)) begin
        errors++;
        $display("FAIL mem_addr got=%h expected=%h", last_addr, addr & ~32'hF);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.ifq_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got=%b%b expected=00", bus.mem_req, bus.ifq_dout_valid);
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.ifq_dout !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h/%h expected=0", bus.mem_addr, bus.ifq_dout);
    end
    checks++;
    if (bus.ifq_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b expected=1", bus.ifq_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_miss;
    do_fetch(32'h40, 1'b1, -1, -1, 6);
    checks++;
    if (last_dout !== 128'h00000044_00000033_00000022_00000011) begin
      errors++;
      $display("FAIL miss_line got=%h expected=00000044_00000033_00000022_00000011", last_dout);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.ifq_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width got=%b expected=0", bus.ifq_dout_valid);
    end
  endtask

  task automatic test_hit;
    do_fetch(32'h4C, 1'b0, -1, -1, 0);
  endtask

  task automatic test_back_to_back;
    int r0, b0;
    r0 = rcv; b0 = bursts;
    exp_q.push_back(line_of(32'h40));
    exp_q.push_back(line_of(32'h44));
    @(negedge clk);
    bus.ifq_pcin = 32'h40;
    bus.ifq_ren = 1'b1;
    @(negedge clk);
    bus.ifq_pcin = 32'h44;
    #1;
    checks++;
    if (rcv != r0 + 1) begin
      errors++;
      $display("FAIL b2b_first got=%0d expected=1", rcv - r0);
    end
    @(negedge clk);
    bus.ifq_ren = 1'b0;
    #1;
    checks++;
    if (rcv != r0 + 2) begin
      errors++;
      $display("FAIL b2b_second got=%0d expected=2", rcv - r0);
    end
    checks++;
    if (bursts != b0) begin
      errors++;
      $display("FAIL b2b_bursts got=%0d expected=0", bursts - b0);
    end
    exp_hits += 2;
  endtask

  task automatic test_eviction;
    gnt_wait = 2;
    do_fetch(32'h440, 1'b1, -1, -1, 8);
    gnt_wait = 0;
    do_fetch(32'h40, 1'b1, -1, -1, 6);
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf;
    @(negedge clk);
    checks++;
    if (perf_hit_cnt !== 32'(exp_hits) || perf_miss_cnt !== 32'(exp_misses)) begin
      errors++;
      $display("FAIL perf got=%0d/%0d expected=%0d/%0d",
               perf_hit_cnt, perf_miss_cnt, exp_hits, exp_misses);
    end
  endtask
`endif

  task automatic test_abort;
    int r0, b0;
    do_fetch(32'h80, 1'b1, 2, -1, 0);
    do_fetch(32'h80, 1'b0, -1, -1, 0);
    r0 = rcv; b0 = bursts;
    @(negedge clk);
    bus.ifq_pcin = 32'hC0;
    bus.ifq_ren = 1'b1;
    bus.ifq_abort = 1'b1;
    repeat (3) @(negedge clk);
    bus.ifq_ren = 1'b0;
    bus.ifq_abort = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (rcv != r0 || bursts != b0) begin
      errors++;
      $display("FAIL abort_ren got=%0d/%0d expected=0/0", rcv - r0, bursts - b0);
    end
  endtask

  task automatic test_flush;
    do_fetch(32'h40, 1'b0, -1, -1, 0);
    @(negedge clk);
    bus.ic_flush = 1'b1;
    @(negedge clk);
    bus.ic_flush = 1'b0;
    do_fetch(32'h40, 1'b1, -1, -1, 6);
    do_fetch(32'h100, 1'b1, -1, 1, 6);
    do_fetch(32'h100, 1'b1, -1, -1, 6);
  endtask

  task automatic test_reset_mid_fill;
    int r0, n;
    r0 = rcv; n = 0;
    @(negedge clk);
    bus.ifq_pcin = 32'h200;
    bus.ifq_ren = 1'b1;
    @(negedge clk);
    bus.ifq_ren = 1'b0;
    #1;
    while (cur_beat != 1 && n < 30) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 30) begin
      errors++;
      $display("FAIL midfill_wait got=no beat expected=beat 1");
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.ifq_dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL midfill_reset got=%b%b expected=00", bus.mem_req, bus.ifq_dout_valid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (rcv != r0) begin
      errors++;
      $display("FAIL midfill_resp got=%0d expected=0", rcv - r0);
    end
    do_fetch(32'h40, 1'b1, -1, -1, 6);
    do_fetch(32'h80, 1'b1, -1, -1, 6);
  endtask

  initial begin
    bus.ifq_pcin = '0;
    bus.ifq_ren = 1'b0;
    bus.ifq_abort = 1'b0;
    bus.ic_flush = 1'b0;
    test_reset;
    test_miss;
    test_hit;
    test_back_to_back;
    test_eviction;
`ifdef ICACHE_PERF_CNT_EN
    test_perf;
`endif
    test_abort;
    test_flush;
    test_reset_mid_fill;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got=%0d pending expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
